// File: rtl/mc_fifo_core.sv
// Single-clock multi-channel FIFO: NUM_CH logical queues share one block-RAM array.
// Optional sticky overflow/underflow flags are built when MC_FIFO_ERR_EN is defined.
module mc_fifo_core #(
    parameter type DATA_t    = logic,
    parameter int  NUM_CH    = 4,
    parameter int  DEPTH     = 16,
    parameter int  AFULL_LVL = DEPTH - 2,
    localparam int CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       wr_en_i,
    input  logic [CHW-1:0]             wr_ch_i,
    input  DATA_t                      wdata_i,
    input  logic                       rd_en_i,
    input  logic [CHW-1:0]             rd_ch_i,
    input  logic [NUM_CH-1:0]          flush_i,
    output DATA_t                      rdata_o,
    output logic                       rvalid_o,
    output logic [CHW-1:0]             rch_o,
    output logic [NUM_CH-1:0][CW-1:0]  count_o,
    output logic [NUM_CH-1:0]          empty_o,
    output logic [NUM_CH-1:0]          full_o,
    output logic [NUM_CH-1:0]          afull_o,
    output logic [NUM_CH-1:0]          ovf_o,
    output logic [NUM_CH-1:0]          udf_o
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int MEMW = $clog2(NUM_CH * DEPTH);

    typedef logic [CHW-1:0]  ch_t;
    typedef logic [CW-1:0]   cnt_t;
    typedef logic [PTRW-1:0] ptr_t;

    localparam cnt_t FULL_CNT  = cnt_t'(DEPTH);
    localparam cnt_t AFULL_CNT = cnt_t'(AFULL_LVL);

    DATA_t mem [NUM_CH*DEPTH];

    ptr_t  wptr_q [NUM_CH];
    ptr_t  wptr_d [NUM_CH];
    ptr_t  rptr_q [NUM_CH];
    ptr_t  rptr_d [NUM_CH];
    cnt_t  cnt_q  [NUM_CH];
    cnt_t  cnt_d  [NUM_CH];

    DATA_t rdata_q;
    logic  rvalid_q;
    ch_t   rch_q;

    ch_t               wch;
    ch_t               rch;
    logic [MEMW-1:0]   waddr;
    logic [MEMW-1:0]   raddr;
    logic              push_acc;
    logic              pop_acc;
    logic [NUM_CH-1:0] push_sel;
    logic [NUM_CH-1:0] pop_sel;
    logic [NUM_CH-1:0] empty_s;
    logic [NUM_CH-1:0] full_s;
    logic [NUM_CH-1:0] afull_s;

    // With a single queue the channel inputs carry no information and the address is the pointer alone.
    if (NUM_CH > 1) begin : g_multi
        assign wch   = wr_ch_i;
        assign rch   = rd_ch_i;
        assign waddr = {wr_ch_i, wptr_q[wr_ch_i]};
        assign raddr = {rd_ch_i, rptr_q[rd_ch_i]};
    end else begin : g_single
        assign wch   = '0;
        assign rch   = '0;
        assign waddr = wptr_q[0];
        assign raddr = rptr_q[0];
    end

    always_comb begin
        empty_s = '0;
        full_s  = '0;
        afull_s = '0;
        count_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            empty_s[c] = (cnt_q[c] == '0);
            full_s[c]  = (cnt_q[c] == FULL_CNT);
            afull_s[c] = (cnt_q[c] >= AFULL_CNT);
            count_o[c] = cnt_q[c];
        end
    end

    assign empty_o = empty_s;
    assign full_o  = full_s;
    assign afull_o = afull_s;

    // Acceptance looks only at pre-edge state, so a same-cycle pop never frees room for a push.
    assign push_acc = wr_en_i & ~full_s[wch]  & ~flush_i[wch];
    assign pop_acc  = rd_en_i & ~empty_s[rch] & ~flush_i[rch];
    assign push_sel = NUM_CH'(push_acc) << wch;
    assign pop_sel  = NUM_CH'(pop_acc)  << rch;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            wptr_d[c] = wptr_q[c];
            rptr_d[c] = rptr_q[c];
            cnt_d[c]  = cnt_q[c];
            if (flush_i[c]) begin
                wptr_d[c] = '0;
                rptr_d[c] = '0;
                cnt_d[c]  = '0;
            end else begin
                if (push_sel[c]) begin
                    wptr_d[c] = wptr_q[c] + 1'b1;
                end
                if (pop_sel[c]) begin
                    rptr_d[c] = rptr_q[c] + 1'b1;
                end
                case ({push_sel[c], pop_sel[c]})
                    2'b10:   cnt_d[c] = cnt_q[c] + 1'b1;
                    2'b01:   cnt_d[c] = cnt_q[c] - 1'b1;
                    default: cnt_d[c] = cnt_q[c];
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                wptr_q[c] <= wptr_d[c];
                rptr_q[c] <= rptr_d[c];
                cnt_q[c]  <= cnt_d[c];
            end
        end
    end

    // No reset on the array so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (push_acc) begin
            mem[waddr] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q  <= '0;
            rch_q    <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= pop_acc;
            if (pop_acc) begin
                rdata_q <= mem[raddr];
                rch_q   <= rd_ch_i;
            end
        end
    end

    assign rdata_o  = rdata_q;
    assign rch_o    = rch_q;
    assign rvalid_o = rvalid_q;

`ifdef MC_FIFO_ERR_EN
    logic [NUM_CH-1:0] ovf_q;
    logic [NUM_CH-1:0] udf_q;
    logic [NUM_CH-1:0] ovf_set;
    logic [NUM_CH-1:0] udf_set;

    // A flushed channel never flags: the flush, not the full/empty state, dropped the request.
    assign ovf_set = NUM_CH'(wr_en_i & full_s[wch]  & ~flush_i[wch]) << wch;
    assign udf_set = NUM_CH'(rd_en_i & empty_s[rch] & ~flush_i[rch]) << rch;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= '0;
            udf_q <= '0;
        end else begin
            ovf_q <= ovf_q | ovf_set;
            udf_q <= udf_q | udf_set;
        end
    end

    assign ovf_o = ovf_q;
    assign udf_o = udf_q;
`else
    assign ovf_o = '0;
    assign udf_o = '0;
`endif

endmodule
